// File: rtl/handshake_receiver_if.sv
// Bundle for the four-phase REQ/ACK crossing plus the sink-side valid/ready port.
// The master side drives request, data and ready. The slave side is the receiver.
interface handshake_receiver_if #(
    parameter int DATA_WIDTH  = 1,
    parameter int COUNT_WIDTH = 16
);
    logic                   asyncRequest;
    logic [DATA_WIDTH-1:0]  asyncData;
    logic                   asyncAcknowledge;
    logic                   sinkValid;
    logic                   sinkReady;
    logic [DATA_WIDTH-1:0]  sinkData;
    logic [COUNT_WIDTH-1:0] transferCount;

    modport master (
        output asyncRequest,
        output asyncData,
        output sinkReady,
        input  asyncAcknowledge,
        input  sinkValid,
        input  sinkData,
        input  transferCount
    );

    modport slave (
        input  asyncRequest,
        input  asyncData,
        input  sinkReady,
        output asyncAcknowledge,
        output sinkValid,
        output sinkData,
        output transferCount
    );
endinterface

// File: rtl/handshake_receiver.sv
// Sink-side endpoint of a four-phase bundled-data REQ/ACK clock-domain crossing.
// Define HANDSHAKE_RECEIVER_EARLY_ACK_EN for early acknowledge with a one-word buffer.
module handshake_receiver #(
    parameter int DATA_WIDTH         = 1,
    parameter int SYNCHRONIZER_WIDTH = 2,
    parameter int COUNT_WIDTH        = 16
) (
    input  logic                sinkClock,
    input  logic                sinkReset_n,
    handshake_receiver_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        PRESENT,
        RELEASE
    } state_t;

    state_t                        state;
    logic [SYNCHRONIZER_WIDTH-1:0] syncStages;
    logic                          syncRequest;
    logic                          accept;

    assign syncRequest = syncStages[SYNCHRONIZER_WIDTH-1];
    assign accept      = bus.sinkValid && bus.sinkReady;

    // Only the request crosses domains; data is qualified by syncRequest.
    always_ff @(posedge sinkClock or negedge sinkReset_n) begin
        if (!sinkReset_n) begin
            syncStages <= '0;
        end else begin
            syncStages <= {syncStages[SYNCHRONIZER_WIDTH-2:0], bus.asyncRequest};
        end
    end

    always_ff @(posedge sinkClock or negedge sinkReset_n) begin
        if (!sinkReset_n) begin
            bus.transferCount <= '0;
        end else if (accept) begin
            bus.transferCount <= bus.transferCount + 1'b1;
        end
    end

    always_ff @(posedge sinkClock or negedge sinkReset_n) begin
        if (!sinkReset_n) begin
            state                <= IDLE;
            bus.asyncAcknowledge <= 1'b0;
            bus.sinkValid        <= 1'b0;
            bus.sinkData         <= '0;
        end else begin
            unique case (state)
`ifdef HANDSHAKE_RECEIVER_EARLY_ACK_EN
                // Capture may overlap delivery of the buffered word.
                IDLE: begin
                    if (syncRequest && (!bus.sinkValid || bus.sinkReady)) begin
                        bus.sinkData         <= bus.asyncData;
                        bus.sinkValid        <= 1'b1;
                        bus.asyncAcknowledge <= 1'b1;
                        state                <= RELEASE;
                    end else if (accept) begin
                        bus.sinkValid <= 1'b0;
                    end
                end
                RELEASE: begin
                    if (accept) begin
                        bus.sinkValid <= 1'b0;
                    end
                    if (!syncRequest) begin
                        bus.asyncAcknowledge <= 1'b0;
                        state                <= IDLE;
                    end
                end
`else
                IDLE: begin
                    if (syncRequest) begin
                        bus.sinkData  <= bus.asyncData;
                        bus.sinkValid <= 1'b1;
                        state         <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (accept) begin
                        bus.sinkValid        <= 1'b0;
                        bus.asyncAcknowledge <= 1'b1;
                        state                <= RELEASE;
                    end
                end
                RELEASE: begin
                    if (!syncRequest) begin
                        bus.asyncAcknowledge <= 1'b0;
                        state                <= IDLE;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_handshake_receiver.sv
// Directed bench for handshake_receiver: vector table plus multi-cycle sequences.
// A second instance with a 4-bit counter shares the stimulus to exercise wrap.
module tb_handshake_receiver;
    localparam int DW = 8;

    logic sinkClock = 1'b0;
    logic sinkReset_n;

    always #5 sinkClock = ~sinkClock;

    handshake_receiver_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(16)) b16 ();
    handshake_receiver_if #(.DATA_WIDTH(DW), .COUNT_WIDTH(4))  b4 ();

    assign b4.asyncRequest = b16.asyncRequest;
    assign b4.asyncData    = b16.asyncData;
    assign b4.sinkReady    = b16.sinkReady;

    handshake_receiver #(
        .DATA_WIDTH(DW),
        .SYNCHRONIZER_WIDTH(2),
        .COUNT_WIDTH(16)
    ) dut16 (
        .sinkClock(sinkClock),
        .sinkReset_n(sinkReset_n),
        .bus(b16)
    );

    handshake_receiver #(
        .DATA_WIDTH(DW),
        .SYNCHRONIZER_WIDTH(2),
        .COUNT_WIDTH(4)
    ) dut4 (
        .sinkClock(sinkClock),
        .sinkReset_n(sinkReset_n),
        .bus(b4)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic          req;
        logic [DW-1:0] data;
        logic          rdy;
        logic          expValid;
        logic [DW-1:0] expData;
        logic          expAck;
        logic [15:0]   expCount;
    } vec_t;

    vec_t          vecs[$];
    logic [DW-1:0] sent[$];
    logic [DW-1:0] got[$];

    always @(posedge sinkClock) begin
        if (sinkReset_n && b16.sinkValid && b16.sinkReady) begin
            got.push_back(b16.sinkData);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void addVec(input logic req, input logic [DW-1:0] data, input logic rdy,
                                   input logic v, input logic [DW-1:0] d, input logic a,
                                   input logic [15:0] c);
        vec_t t;
        t.req = req;
        t.data = data;
        t.rdy = rdy;
        t.expValid = v;
        t.expData = d;
        t.expAck = a;
        t.expCount = c;
        vecs.push_back(t);
    endfunction

    task automatic doReset();
        @(negedge sinkClock);
        b16.asyncRequest = 1'b0;
        b16.sinkReady    = 1'b0;
        sinkReset_n      = 1'b0;
        @(negedge sinkClock);
        sinkReset_n = 1'b1;
    endtask

    task automatic transfer(input logic [DW-1:0] d, input int delay);
        int n;
        @(negedge sinkClock);
        b16.asyncData    = d;
        b16.asyncRequest = 1'b1;
        sent.push_back(d);
        n = 0;
        while (!b16.sinkValid && n < 20) begin
            @(posedge sinkClock);
            #1;
            n++;
        end
        check("valid_wait", 32'(b16.sinkValid), 32'd1);
        repeat (delay) @(negedge sinkClock);
        @(negedge sinkClock);
        b16.sinkReady = 1'b1;
        @(posedge sinkClock);
        #1;
        check("ack_on_accept", 32'(b16.asyncAcknowledge), 32'd1);
        @(negedge sinkClock);
        b16.sinkReady    = 1'b0;
        b16.asyncRequest = 1'b0;
        n = 0;
        while (b16.asyncAcknowledge && n < 20) begin
            @(posedge sinkClock);
            #1;
            n++;
        end
        check("ack_fall_wait", 32'(b16.asyncAcknowledge), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] wrapExp[3];
        wrapExp[0] = 4'd15;
        wrapExp[1] = 4'd0;
        wrapExp[2] = 4'd1;

        // Reset held with request already high.
        sinkReset_n      = 1'b0;
        b16.asyncRequest = 1'b1;
        b16.asyncData    = 8'h5A;
        b16.sinkReady    = 1'b0;
        repeat (3) @(posedge sinkClock);
        #1;
        check("rst_valid", 32'(b16.sinkValid), 32'd0);
        check("rst_data", 32'(b16.sinkData), 32'd0);
        check("rst_ack", 32'(b16.asyncAcknowledge), 32'd0);
        check("rst_count16", 32'(b16.transferCount), 32'd0);
        check("rst_count4", 32'(b4.transferCount), 32'd0);
        @(negedge sinkClock);
        sinkReset_n = 1'b1;
        @(posedge sinkClock);
        #1;
        check("rel_edge1_valid", 32'(b16.sinkValid), 32'd0);
        @(posedge sinkClock);
        #1;
        check("rel_edge2_valid", 32'(b16.sinkValid), 32'd0);
        @(posedge sinkClock);
        #1;
        check("rel_edge3_valid", 32'(b16.sinkValid), 32'd1);
        check("rel_edge3_data", 32'(b16.sinkData), 32'h5A);
        #2;
        sinkReset_n = 1'b0;
        #1;
        check("async_rst_valid", 32'(b16.sinkValid), 32'd0);
        check("async_rst_data", 32'(b16.sinkData), 32'd0);

`ifndef HANDSHAKE_RECEIVER_EARLY_ACK_EN
        doReset();
        // Single transfer with ready already high.
        addVec(1, 8'hA5, 1, 0, 8'h00, 0, 0);
        addVec(1, 8'hA5, 1, 0, 8'h00, 0, 0);
        addVec(1, 8'hA5, 1, 1, 8'hA5, 0, 0);
        addVec(1, 8'hA5, 1, 0, 8'hA5, 1, 1);
        addVec(0, 8'hA5, 1, 0, 8'hA5, 1, 1);
        addVec(0, 8'hA5, 1, 0, 8'hA5, 1, 1);
        addVec(0, 8'hA5, 1, 0, 8'hA5, 0, 1);
        addVec(0, 8'hFF, 1, 0, 8'hA5, 0, 1);
        // Backpressure.
        addVec(1, 8'h3C, 0, 0, 8'hA5, 0, 1);
        addVec(1, 8'h3C, 0, 0, 8'hA5, 0, 1);
        addVec(1, 8'h3C, 0, 1, 8'h3C, 0, 1);
        for (int i = 0; i < 10; i++) begin
            addVec(1, 8'h3C, 0, 1, 8'h3C, 0, 1);
        end
        addVec(1, 8'h3C, 1, 0, 8'h3C, 1, 2);
        addVec(0, 8'h3C, 0, 0, 8'h3C, 1, 2);
        addVec(0, 8'h3C, 0, 0, 8'h3C, 1, 2);
        addVec(0, 8'h3C, 0, 0, 8'h3C, 0, 2);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge sinkClock);
            b16.asyncRequest = vecs[i].req;
            b16.asyncData    = vecs[i].data;
            b16.sinkReady    = vecs[i].rdy;
            @(posedge sinkClock);
            #1;
            check($sformatf("vec%0d_valid", i), 32'(b16.sinkValid), 32'(vecs[i].expValid));
            check($sformatf("vec%0d_data", i), 32'(b16.sinkData), 32'(vecs[i].expData));
            check($sformatf("vec%0d_ack", i), 32'(b16.asyncAcknowledge), 32'(vecs[i].expAck));
            check($sformatf("vec%0d_count16", i), 32'(b16.transferCount), 32'(vecs[i].expCount));
            check($sformatf("vec%0d_count4", i), 32'(b4.transferCount), 32'(vecs[i].expCount[3:0]));
        end

        // 100 random words through full four-phase cycles.
        doReset();
        sent.delete();
        got.delete();
        for (int k = 0; k < 100; k++) begin
            transfer(DW'($urandom), $urandom_range(0, 3));
        end
        check("b2b_delivered", 32'(got.size()), 32'd100);
        for (int k = 0; k < 100 && k < got.size(); k++) begin
            check($sformatf("b2b_word%0d", k), 32'(got[k]), 32'(sent[k]));
        end
        check("b2b_count16", 32'(b16.transferCount), 32'd100);
        check("b2b_count4", 32'(b4.transferCount), 32'd4);

        // Counter wrap on the 4-bit instance.
        doReset();
        for (int k = 1; k <= 17; k++) begin
            transfer(DW'(k), 0);
            if (k >= 15) begin
                check($sformatf("wrap_after%0d", k), 32'(b4.transferCount), 32'(wrapExp[k-15]));
            end
        end
        check("wrap_count16", 32'(b16.transferCount), 32'd17);
`else
        doReset();
        @(negedge sinkClock);
        b16.asyncRequest = 1'b1;
        b16.asyncData    = 8'h11;
        repeat (3) @(posedge sinkClock);
        #1;
        check("ea_first_valid", 32'(b16.sinkValid), 32'd1);
        check("ea_first_data", 32'(b16.sinkData), 32'h11);
        check("ea_first_ack", 32'(b16.asyncAcknowledge), 32'd1);
        @(negedge sinkClock);
        b16.asyncRequest = 1'b0;
        repeat (2) @(posedge sinkClock);
        #1;
        check("ea_ack_hold", 32'(b16.asyncAcknowledge), 32'd1);
        @(posedge sinkClock);
        #1;
        check("ea_ack_fall", 32'(b16.asyncAcknowledge), 32'd0);
        check("ea_held_valid", 32'(b16.sinkValid), 32'd1);
        @(negedge sinkClock);
        b16.asyncRequest = 1'b1;
        b16.asyncData    = 8'h22;
        repeat (5) @(posedge sinkClock);
        #1;
        check("ea_stall_data", 32'(b16.sinkData), 32'h11);
        check("ea_stall_ack", 32'(b16.asyncAcknowledge), 32'd0);
        check("ea_stall_count", 32'(b16.transferCount), 32'd0);
        @(negedge sinkClock);
        b16.sinkReady = 1'b1;
        @(posedge sinkClock);
        #1;
        check("ea_load_valid", 32'(b16.sinkValid), 32'd1);
        check("ea_load_data", 32'(b16.sinkData), 32'h22);
        check("ea_load_ack", 32'(b16.asyncAcknowledge), 32'd1);
        check("ea_load_count", 32'(b16.transferCount), 32'd1);
        @(posedge sinkClock);
        #1;
        check("ea_drain_valid", 32'(b16.sinkValid), 32'd0);
        check("ea_drain_count", 32'(b16.transferCount), 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
